// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package seq_shift_unit_pkg;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASL = 2'b10,
      OP_ASR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// One 1-bit shift step plus the MSB-change flag for that step.
module shift_step
   import seq_shift_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] y,
   input  op_e              op,
   output logic [WIDTH-1:0] y_nxt,
   output logic             of_bit
);

   always_comb begin
      y_nxt = y;
      case (op)
         OP_LSL, OP_ASL: y_nxt = {y[WIDTH-2:0], 1'b0};
         OP_LSR:         y_nxt = {1'b0, y[WIDTH-1:1]};
         OP_ASR:         y_nxt = {y[WIDTH-1], y[WIDTH-1:1]};
         default:        y_nxt = y;
      endcase
      of_bit = y[WIDTH-1] ^ y_nxt[WIDTH-1];
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Shift sequencer: latches an operand and applies one 1-bit shift per clock,
// accumulating a sticky overflow, with a start/busy/done handshake.
module seq_shift_unit
   import seq_shift_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] A,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             OF
);

   state_e           state, state_nxt;
   op_e              op_r;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] y_step;
   logic             of_step;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .y      (Y),
      .op     (op_r),
      .y_nxt  (y_step),
      .of_bit (of_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (cnt == AMT_W'(1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand/op latch happens only on acceptance, so inputs may change freely afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Y    <= '0;
         OF   <= 1'b0;
         cnt  <= '0;
         op_r <= OP_LSL;
      end else if (accept) begin
         Y    <= A;
         OF   <= 1'b0;
         cnt  <= amt;
         op_r <= op_e'(op);
      end else if (state == S_SHIFT) begin
         Y    <= y_step;
         OF   <= OF | of_step;
         cnt  <= cnt - AMT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit with an expected-result queue.
module tb_seq_shift_unit;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned AMT_W = 4;

   typedef struct {
      logic [WIDTH-1:0] y;
      logic             of;
      int               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] A;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Y;
   logic             OF;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .A     (A),
      .busy  (busy),
      .done  (done),
      .Y     (Y),
      .OF    (OF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one operation from a negedge; optionally re-pulses start mid-run with A=FFFF.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [AMT_W-1:0] n,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] ey,
                         input logic ef, input logic repulse);
      exp_t e, got;
      int   cyc, busy_cnt;
      bit   seen;
      e.y = ey; e.of = ef; e.lat = int'(n) + 1;
      sb.push_back(e);
      op = o; amt = n; A = a; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = ~o; amt = ~n; A = ~a;
      cyc = 1; busy_cnt = 0; seen = 0;
      while (cyc <= 40 && !seen) begin
         if (busy) busy_cnt++;
         if (done) seen = 1;
         else begin
            if (repulse && cyc == 1) begin
               start = 1'b1; A = 16'hFFFF; op = 2'b11; amt = 4'd15;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      got = sb.pop_front();
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
         chk({tag, " Y"}, 32'(Y), 32'(got.y));
         chk({tag, " OF"}, 32'(OF), 32'(got.of));
         chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(n));
         @(negedge clk);
         chk({tag, " done_pulse"}, 32'(done), 32'd0);
         chk({tag, " Y_held"}, 32'(Y), 32'(got.y));
         chk({tag, " OF_held"}, 32'(OF), 32'(got.of));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; amt = '0; A = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset Y", 32'(Y), 32'd0);
      chk("reset OF", 32'(OF), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("lsl4",     2'b00, 4'd4,  16'h0001, 16'h0010, 1'b0, 1'b0);
      run_op("asr3",     2'b11, 4'd3,  16'h8000, 16'hF000, 1'b0, 1'b0);
      run_op("asl1",     2'b10, 4'd1,  16'h4000, 16'h8000, 1'b1, 1'b0);
      run_op("asl2",     2'b10, 4'd2,  16'h4000, 16'h0000, 1'b1, 1'b0);
      run_op("lsr15",    2'b01, 4'd15, 16'h8001, 16'h0001, 1'b1, 1'b0);
      run_op("amt0",     2'b01, 4'd0,  16'h1234, 16'h1234, 1'b0, 1'b0);
      run_op("repulse",  2'b00, 4'd2,  16'h0003, 16'h000C, 1'b0, 1'b1);
      run_op("lsr_msb0", 2'b01, 4'd3,  16'h7FF8, 16'h0FFF, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a running shift.
      op = 2'b00; amt = 4'd8; A = 16'h00F3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst done", 32'(done), 32'd0);
      chk("mid_rst Y", 32'(Y), 32'd0);
      chk("mid_rst OF", 32'(OF), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op("post_rst", 2'b00, 4'd4, 16'h0001, 16'h0010, 1'b0, 1'b0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
